// File: rtl/adc_avg_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_decimator_if
// Description : Sample-in / result-out bundle for the ADC averaging
//               decimator.
//               master : ADC and back-end side (drives en, din, din_valid,
//                        dout_ready; observes results and status)
//               slave  : decimator side
//               Signals: en, din[BITS], din_valid, dout[BITS], dout_valid,
//                        dout_ready, overrun, sample_cnt[LOG2_N+1]
// Revision    : 1.0 - initial release
// ============================================================================
interface adc_avg_decimator_if #(
    parameter int BITS   = 4,
    parameter int LOG2_N = 2
);
    logic              en;
    logic [BITS-1:0]   din;
    logic              din_valid;
    logic [BITS-1:0]   dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              overrun;
    logic [LOG2_N:0]   sample_cnt;

    modport master (
        output en, din, din_valid, dout_ready,
        input  dout, dout_valid, overrun, sample_cnt
    );

    modport slave (
        input  en, din, din_valid, dout_ready,
        output dout, dout_valid, overrun, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/adc_avg_decimator.sv
`default_nettype none
// ============================================================================
// Module      : adc_avg_decimator
// Description : Averages 2^LOG2_N consecutive ADC codes (round half up) and
//               presents one code per block over a valid/ready handshake.
//               A sticky overrun flag records a result overwritten before
//               the consumer took it.
//               Ports: clk        - system clock (rising edge)
//                      rst        - synchronous active-high reset
//                      bus.slave  - en, din, din_valid, dout_ready in;
//                                   dout, dout_valid, overrun, sample_cnt out
// Revision    : 1.0 - initial release
// ============================================================================
module adc_avg_decimator #(
    parameter int BITS   = 4,
    parameter int LOG2_N = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    adc_avg_decimator_if.slave   bus
);

    // Accumulator sized for N full-scale codes, so it never wraps.
    localparam int c_acc_w = BITS + LOG2_N;
    localparam logic [LOG2_N:0]    c_last = (LOG2_N+1)'((1 << LOG2_N) - 1);
    // Half an LSB of the shifted result; zero for pass-through.
    localparam logic [c_acc_w-1:0] c_half = c_acc_w'((1 << LOG2_N) >> 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_take;
    logic                w_last;
    logic                w_clear;
    logic [c_acc_w-1:0]  r_acc;
    logic [LOG2_N:0]     r_cnt;
    logic [BITS-1:0]     r_dout;
    logic                r_dout_valid;
    logic                r_overrun;
    logic [c_acc_w-1:0]  w_sum;
    logic [c_acc_w-1:0]  w_rnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The first sample is taken in the same cycle en is seen in IDLE, so
    // sample acceptance is identical in both states; the state only tracks
    // whether a block is open.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_last      = 1'b0;
        w_clear     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clear = !bus.en;
                if (bus.en) begin
                    w_state_nxt = ST_ACC;
                    w_take      = bus.din_valid;
                end
            end
            ST_ACC: begin
                if (bus.en) begin
                    w_take = bus.din_valid;
                end else begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_clear     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_last = w_take && (r_cnt == c_last);
    end

    // din only reaches the accumulator through w_take, so an undefined code
    // on an invalid cycle cannot leak into r_acc.
    assign w_sum = r_acc + c_acc_w'(bus.din);
    assign w_rnd = w_sum + c_half;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_clear || w_last) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_take) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + (LOG2_N+1)'(1);
            end

            // A completion wins over a same-edge take: dout_valid stays set
            // with the new code. Overrun only if the old code was not taken.
            if (w_last) begin
                r_dout       <= BITS'(w_rnd >> LOG2_N);
                r_dout_valid <= 1'b1;
                if (r_dout_valid && !bus.dout_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && bus.dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.dout       = r_dout;
    assign bus.dout_valid = r_dout_valid;
    assign bus.overrun    = r_overrun;
    assign bus.sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_avg_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_avg_decimator
// Description : Self-checking bench for adc_avg_decimator. One instance with
//               N=4 covers averaging, handshake, overrun, abort and reset;
//               a second with N=1 covers pass-through. Expected codes come
//               from a bench-side running-sum model through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_avg_decimator;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    int   q_exp[$];
    int   q_pt[$];
    int   m_acc = 0;
    int   m_cnt = 0;

    adc_avg_decimator_if #(.BITS(4), .LOG2_N(2)) bus  ();
    adc_avg_decimator_if #(.BITS(4), .LOG2_N(0)) bus0 ();

    adc_avg_decimator #(.BITS(4), .LOG2_N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    adc_avg_decimator #(.BITS(4), .LOG2_N(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one valid sample (en assumed high) and advances the model.
    task automatic feed(input int v);
        bus.din       = 4'(v);
        bus.din_valid = 1'b1;
        m_acc += v;
        m_cnt++;
        if (m_cnt == 4) begin
            q_exp.push_back((m_acc + 2) >> 2);
            m_acc = 0;
            m_cnt = 0;
        end
        tick();
        bus.din_valid = 1'b0;
        bus.din       = 4'($urandom);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.din_valid  = 1'b0;
        bus0.din_valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (bus.dout !== 4'd0)       begin errors++; $display("FAIL reset_dout: got %0d want 0", bus.dout); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus.sample_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", bus.sample_cnt); end
        checks++; if (bus0.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_pt_valid: got %b want 0", bus0.dout_valid); end
    endtask

    task automatic test_rounding();
        int e;
        bus.en = 1'b1;
        bus.dout_ready = 1'b1;
        feed(3); feed(5); feed(7);
        checks++; if (bus.sample_cnt !== 3'd3) begin errors++; $display("FAIL rnd_cnt: got %0d want 3", bus.sample_cnt); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rnd_early_valid: got %b want 0", bus.dout_valid); end
        feed(9);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid: got %b want 1", bus.dout_valid); end
        checks++; if ({28'd0, bus.dout} !== e) begin errors++; $display("FAIL rnd_dout1: got %0d want %0d", bus.dout, e); end
        tick();
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rnd_pulse: got %b want 0", bus.dout_valid); end
        feed(1); feed(2); feed(2); feed(2);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e) begin errors++; $display("FAIL rnd_dout2: got %0d want %0d", bus.dout, e); end
    endtask

    task automatic test_full_scale();
        int e;
        for (int i = 0; i < 4; i++) feed(15);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL full_scale: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
        for (int i = 0; i < 4; i++) feed(0);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL zero_scale: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
    endtask

    task automatic test_back_to_back();
        int e;
        int results = 0;
        for (int i = 1; i <= 8; i++) begin
            feed(i);
            if (bus.dout_valid === 1'b1) begin
                results++;
                e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
                checks++; if ({28'd0, bus.dout} !== e) begin errors++; $display("FAIL b2b_dout: got %0d want %0d", bus.dout, e); end
            end
        end
        checks++; if (results != 2)      begin errors++; $display("FAIL b2b_count: got %0d want 2", results); end
        checks++; if (q_exp.size() != 0) begin errors++; $display("FAIL b2b_pending: got %0d want 0", q_exp.size()); end
    endtask

    task automatic test_overrun();
        int e;
        tick();
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(4);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_blk1: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_early: got %b want 0", bus.overrun); end
        for (int i = 0; i < 4; i++) feed(10);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL ovr_blk2: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", bus.overrun); end
        bus.dout_ready = 1'b1;
        tick();
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL ovr_take: got %b want 0", bus.dout_valid); end
        checks++; if (bus.overrun !== 1'b1)    begin errors++; $display("FAIL ovr_sticky: got %b want 1", bus.overrun); end
    endtask

    task automatic test_same_edge();
        int e;
        test_reset();
        m_acc = 0; m_cnt = 0; q_exp.delete();
        bus.en = 1'b1;
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 4; i++) feed(1);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL se_blk1: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
        feed(2); feed(2); feed(2);
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL se_stable: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
        bus.dout_ready = 1'b1;
        feed(6);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL se_new: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL se_overrun: got %b want 0", bus.overrun); end
        tick();
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL se_drop: got %b want 0", bus.dout_valid); end
    endtask

    task automatic test_abort();
        int e;
        bus.dout_ready = 1'b1;
        feed(5); feed(5);
        checks++; if (bus.sample_cnt !== 3'd2) begin errors++; $display("FAIL abort_pre_cnt: got %0d want 2", bus.sample_cnt); end
        bus.en        = 1'b0;
        bus.din       = 4'd15;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
        m_acc = 0; m_cnt = 0;
        checks++; if (bus.sample_cnt !== 3'd0) begin errors++; $display("FAIL abort_cnt: got %0d want 0", bus.sample_cnt); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.dout_valid); end
        bus.en = 1'b1;
        for (int i = 0; i < 4; i++) feed(8);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL abort_dout: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
    endtask

    task automatic test_reset_mid_block();
        int e;
        tick();
        bus.dout_ready = 1'b0;
        for (int i = 0; i < 8; i++) feed(3);
        checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL rmb_pre_overrun: got %b want 1", bus.overrun); end
        q_exp.delete();
        feed(7); feed(7); feed(7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_acc = 0; m_cnt = 0;
        checks++; if (bus.dout !== 4'd0)       begin errors++; $display("FAIL rmb_dout: got %0d want 0", bus.dout); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rmb_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL rmb_overrun: got %b want 0", bus.overrun); end
        checks++; if (bus.sample_cnt !== 3'd0) begin errors++; $display("FAIL rmb_cnt: got %0d want 0", bus.sample_cnt); end
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) feed(12);
        e = (q_exp.size() > 0) ? q_exp.pop_front() : -1;
        checks++; if ({28'd0, bus.dout} !== e || bus.dout_valid !== 1'b1) begin errors++; $display("FAIL rmb_dout2: got %0d/%b want %0d/1", bus.dout, bus.dout_valid, e); end
    endtask

    task automatic test_passthrough();
        int e;
        int vals[5] = '{0, 9, 15, 1, 6};
        bus0.en = 1'b1;
        bus0.dout_ready = 1'b1;
        foreach (vals[i]) begin
            bus0.din       = 4'(vals[i]);
            bus0.din_valid = 1'b1;
            q_pt.push_back(vals[i]);
            tick();
            bus0.din_valid = 1'b0;
            bus0.din       = 4'($urandom);
            e = (q_pt.size() > 0) ? q_pt.pop_front() : -1;
            checks++; if ({28'd0, bus0.dout} !== e || bus0.dout_valid !== 1'b1) begin errors++; $display("FAIL pt_dout: got %0d/%b want %0d/1", bus0.dout, bus0.dout_valid, e); end
            checks++; if (bus0.sample_cnt !== 1'b0) begin errors++; $display("FAIL pt_cnt: got %0d want 0", bus0.sample_cnt); end
        end
        tick();
        checks++; if (bus0.dout_valid !== 1'b0) begin errors++; $display("FAIL pt_idle: got %b want 0", bus0.dout_valid); end
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;  bus.din = '0;  bus.din_valid = 1'b0;  bus.dout_ready = 1'b0;
        bus0.en = 1'b0; bus0.din = '0; bus0.din_valid = 1'b0; bus0.dout_ready = 1'b0;
        test_reset();
        test_rounding();
        test_full_scale();
        test_back_to_back();
        test_overrun();
        test_same_edge();
        test_abort();
        test_reset_mid_block();
        test_passthrough();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_avg_decimator.md
Name: adc_avg_decimator

Overview:
- Digital post-processing stage directly downstream of the SAR ADC model.
- Consumes one ADC output code per conversion and averages 2^LOG2_N consecutive codes with rounding.
- Presents one decimated code per block with a valid/ready handshake to the digital back-end.
- Flags overrun when a new result is produced before the consumer has taken the previous one.

Parameters:
- bits, 4, ADC code width; range 1..24, same meaning as the ADC `bits` parameter.
- log2_n, 2, log2 of the averaging length N; range 0..8; log2_n=0 gives pass-through with registering.

Ports:
- clk  input  1  system clock, same clock that drives the ADC; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  averaging enable; low aborts and clears the current block.
- din  input  bits  ADC code, unsigned.
- din_valid  input  1  din holds a new conversion result this cycle; one sample taken per high cycle.
- dout  output  bits  averaged code, unsigned.
- dout_valid  output  1  dout holds an untaken result.
- dout_ready  input  1  consumer accepts dout when dout_valid && dout_ready.
- overrun  output  1  sticky flag: a result was overwritten before being taken.
- sample_cnt  output  log2_n+1  samples accumulated in the current block (0..N-1); debug/status.

Behaviour:
- Reset (rst=1 at a clk edge) has priority over all other inputs:
  - accumulator, sample_cnt, dout and dout_valid go to 0; overrun goes to 0.
  - The FSM goes to IDLE.
  - A reset mid-block discards partial data; no output is produced for it.
- Accumulator width is bits+log2_n and cannot overflow (max N*(2^bits-1)).
- FSM has two states:
  - IDLE: accumulator=0, sample_cnt=0, din ignored. Go to ACC when en=1; the first sample can be taken in the same cycle that en is seen high.
  - ACC: on en=1 && din_valid=1, acc += din and sample_cnt += 1.
  - When the accepted sample is the Nth (sample_cnt==N-1), the block completes:
    - dout <= (acc + din + 2^(log2_n-1)) >> log2_n, round half up. For log2_n=0, dout <= din.
    - Rounding never exceeds 2^bits-1, so no saturation logic is needed.
    - acc <= 0 and sample_cnt <= 0 in the same edge; the next sample starts a new block, so there are no bubble cycles.
  - en=0 in ACC: return to IDLE next edge, clear acc and sample_cnt. A sample presented in that cycle is dropped.
- Latency: dout/dout_valid update on the same clk edge that captures the Nth valid sample. They are visible the following cycle.
- Output handshake:
  - dout_valid is set on completion.
  - dout_valid is cleared on the edge where dout_valid && dout_ready, unless a completion occurs on that same edge; then it stays 1 with the new dout.
  - dout is stable while dout_valid=1 && dout_ready=0, except on overrun.
- Overrun: completion while dout_valid=1 && dout_ready=0 means the new result overwrites dout, dout_valid stays 1, and overrun <= 1. overrun is cleared only by rst.
- Accept and complete on the same edge is legal and does not set overrun.
- din_valid and dout_ready are independent; dout_ready has no effect on sample acceptance (the ADC cannot be stalled).
- din is unknown/ignored when din_valid=0. X on din with din_valid=0 must not propagate into acc.

Test Plan:
- Rounded average: bits=4, log2_n=2, en=1, dout_ready=1; samples 3,5,7,9 with din_valid=1 → dout=6 with a single-cycle dout_valid pulse on the cycle after the 4th sample. Then samples 1,2,2,2 (sum 7, +2 → 9>>2) → dout=2.
- Full-scale and zero: 4×15 → dout=15, no wrap. Then 4×0 → dout=0. Back-to-back blocks with din_valid held high for 8 cycles → exactly two results, no lost sample.
- Backpressure and overrun: dout_ready=0; feed 8 samples (block1 avg 4, block2 avg 10) → after block1 dout=4, dout_valid=1, overrun=0. After block2 dout=10, overrun=1. Raise dout_ready → dout_valid drops next cycle, overrun stays 1.
- Same-edge take and complete: dout_valid=1, dout_ready=1 on the edge the next block completes → dout shows the new value, dout_valid stays 1, overrun=0.
- Abort: en=0 after 2 samples → sample_cnt=0 next cycle. Re-enable and feed 4 samples of 8 → dout=8, with no contribution from the aborted samples.
- Reset mid-block: rst=1 after 3 samples with overrun=1 → all outputs 0 next cycle. The next 4 samples of 12 → dout=12. Pass-through check with log2_n=0: each din_valid gives dout=din one cycle later.
